// File: rtl/mem_burst_master_if.sv
// rtl/mem_burst_master_if.sv - command, stream and memory bus bundle for mem_burst_master
interface mem_burst_master_if #(
    parameter int AW = 16,
    parameter int DW = 16,
    parameter int LW = 8
) ();
    logic          REQ_VALID;
    logic          REQ_READY;
    logic          REQ_WRITE;
    logic [AW-1:0] REQ_ADDR;
    logic [LW-1:0] REQ_LEN;
    logic [DW-1:0] WDATA;
    logic          WDATA_VALID;
    logic          WDATA_READY;
    logic [DW-1:0] RDATA;
    logic          RDATA_VALID;
    logic          BUSY;
    logic          DONE;
    logic          ERR;
    logic [AW-1:0] ADDR;
    logic [DW-1:0] WDBUS;
    logic [DW-1:0] RDBUS;
    logic          RD;
    logic          WR;

    modport master (
        input  REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_LEN, WDATA, WDATA_VALID, RDBUS,
        output REQ_READY, WDATA_READY, RDATA, RDATA_VALID, BUSY, DONE, ERR,
        output ADDR, WDBUS, RD, WR
    );

    modport slave (
        output REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_LEN, WDATA, WDATA_VALID, RDBUS,
        input  REQ_READY, WDATA_READY, RDATA, RDATA_VALID, BUSY, DONE, ERR,
        input  ADDR, WDBUS, RD, WR
    );
endinterface

// File: rtl/mem_burst_master.sv
// rtl/mem_burst_master.sv - burst read/write initiator for the single-port memory bus (option: MEM_WRAP_CHK_EN)
module mem_burst_master #(
    parameter int AW = 16,
    parameter int DW = 16,
    parameter int LW = 8
) (
    input  logic                CLK,
    input  logic                RST,
    mem_burst_master_if.master  bus
);
    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_FINISH} state_t;

    localparam logic [AW-1:0] ADDR_ONE = AW'(1);
    localparam logic [LW-1:0] LEN_ONE  = LW'(1);

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] cur_addr;
    logic [LW-1:0] remaining;
    logic [DW-1:0] rdata_q;
    logic          rvalid_q;
    logic          accept;
    logic          beat;
    logic          wrap_stop;
    logic          last_beat;

`ifdef MEM_WRAP_CHK_EN
    // a beat at the top address with beats still owed ends the burst early
    assign wrap_stop = (cur_addr == '1) && (remaining != '0);
`else
    assign wrap_stop = 1'b0;
`endif

    assign last_beat       = (remaining == '0) || wrap_stop;
    assign bus.BUSY        = (state != S_IDLE);
    assign bus.RDATA       = rdata_q;
    assign bus.RDATA_VALID = rvalid_q;

    // state register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // next state and bus strobes; write path is combinational from the stream
    always_comb begin
        state_nxt       = state;
        accept          = 1'b0;
        beat            = 1'b0;
        bus.REQ_READY   = 1'b0;
        bus.WDATA_READY = 1'b0;
        bus.RD          = 1'b0;
        bus.WR          = 1'b0;
        bus.ADDR        = '0;
        bus.WDBUS       = '0;
        bus.DONE        = 1'b0;
        case (state)
            S_IDLE: begin
                bus.REQ_READY = 1'b1;
                if (bus.REQ_VALID) begin
                    accept    = 1'b1;
                    state_nxt = bus.REQ_WRITE ? S_WRITE : S_READ;
                end
            end
            S_READ: begin
                bus.RD   = 1'b1;
                bus.ADDR = cur_addr;
                beat     = 1'b1;
                if (last_beat) state_nxt = S_FINISH;
            end
            S_WRITE: begin
                bus.WDATA_READY = 1'b1;
                bus.ADDR        = cur_addr;
                bus.WDBUS       = bus.WDATA;
                bus.WR          = bus.WDATA_VALID;
                beat            = bus.WDATA_VALID;
                if (bus.WDATA_VALID && last_beat) state_nxt = S_FINISH;
            end
            S_FINISH: begin
                bus.DONE  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // burst address/length counters and registered read data
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cur_addr  <= '0;
            remaining <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
        end else begin
            rvalid_q <= 1'b0;
            if (accept) begin
                cur_addr  <= bus.REQ_ADDR;
                remaining <= bus.REQ_LEN;
            end else if (beat) begin
                cur_addr  <= cur_addr + ADDR_ONE;
                remaining <= remaining - LEN_ONE;
            end
            if (state == S_READ) begin
                rdata_q  <= bus.RDBUS;
                rvalid_q <= 1'b1;
            end
        end
    end

`ifdef MEM_WRAP_CHK_EN
    logic err_q;

    // sticky wrap error, cleared by the next accepted command
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)                 err_q <= 1'b0;
        else if (accept)          err_q <= 1'b0;
        else if (beat && wrap_stop) err_q <= 1'b1;
    end

    assign bus.ERR = err_q;
`else
    assign bus.ERR = 1'b0;
`endif
endmodule

// File: tb/tb_mem_burst_master.sv
// tb/tb_mem_burst_master.sv - directed self-checking bench for mem_burst_master
module tb_mem_burst_master;
    logic CLK;
    logic RST;

    mem_burst_master_if bus ();
    mem_burst_master dut (.CLK(CLK), .RST(RST), .bus(bus));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        rd, wr, wready, rvalid, done, busy, rready, err, wd_care;
        logic [15:0] addr, wdbus, rdata;
    } exp_t;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int rd0_cnt = 0;
    bit chk_en = 0;

    exp_t        q[$];
    logic [16:0] sq[$];
    logic [15:0] wq[$];
    logic [15:0] model_mem [0:65535];
    logic [15:0] model_rdata = 16'h0000;
    logic        model_err = 1'b0;

    logic [15:0] mem [0:65535];
    logic        pre_we = 1'b0;
    logic [15:0] pre_addr = 16'h0;
    logic [15:0] pre_data = 16'h0;

    assign bus.RDBUS = bus.RD ? mem[bus.ADDR] : 16'h0000;

    always @(posedge CLK) begin
        if (bus.WR)      mem[bus.ADDR] <= bus.WDBUS;
        else if (pre_we) mem[pre_addr] <= pre_data;
    end

    always @(negedge CLK) begin
        if (bus.DONE === 1'b1) done_cnt++;
        if (bus.RD === 1'b1 && bus.ADDR === 16'h0000) rd0_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t blank();
        exp_t e;
        e.rd = 0; e.wr = 0; e.wready = 0; e.rvalid = 0; e.done = 0; e.busy = 0;
        e.rready = 0; e.err = 0; e.wd_care = 1;
        e.addr = 16'h0; e.wdbus = 16'h0; e.rdata = 16'h0;
        return e;
    endfunction

    function automatic exp_t idle_rec(input logic err, input logic [15:0] rdata);
        exp_t e;
        e = blank();
        e.rready = 1; e.err = err; e.rdata = rdata;
        return e;
    endfunction

    // per-cycle compare against the model's expected trace (idle when the trace is empty)
    always @(negedge CLK) begin
        exp_t e;
        if (chk_en) begin
            if (q.size() > 0) e = q.pop_front();
            else              e = idle_rec(model_err, model_rdata);
            chk("RD", bus.RD, e.rd);
            chk("WR", bus.WR, e.wr);
            chk("WDATA_READY", bus.WDATA_READY, e.wready);
            chk("RDATA_VALID", bus.RDATA_VALID, e.rvalid);
            chk("DONE", bus.DONE, e.done);
            chk("BUSY", bus.BUSY, e.busy);
            chk("REQ_READY", bus.REQ_READY, e.rready);
            chk("ERR", bus.ERR, e.err);
            chk("ADDR", bus.ADDR, e.addr);
            chk("RDATA", bus.RDATA, e.rdata);
            if (e.wd_care) chk("WDBUS", bus.WDBUS, e.wdbus);
        end
    end

    // expected trace of one command, starting with its request cycle
    task automatic build(input bit wr, input logic [15:0] a, input logic [7:0] len, input int gap);
        int beats;
        bit trunc;
        exp_t e;
        logic [15:0] ad;
        logic [15:0] d;
        beats = int'(len) + 1;
        trunc = 0;
`ifdef MEM_WRAP_CHK_EN
        if (int'(a) + int'(len) > 65535) begin
            beats = 65536 - int'(a);
            trunc = 1;
        end
`endif
        q.push_back(idle_rec(model_err, model_rdata));
        model_err = 1'b0;
        for (int k = 0; k < beats; k++) begin
            ad = a + 16'(k);
            if (!wr) begin
                e = blank();
                e.rd = 1; e.addr = ad; e.busy = 1; e.wd_care = 0;
                e.rvalid = (k > 0);
                e.rdata = (k > 0) ? model_mem[ad - 16'd1] : model_rdata;
                q.push_back(e);
            end else begin
                if (k > 0) begin
                    for (int g = 0; g < gap; g++) begin
                        e = blank();
                        e.wready = 1; e.addr = ad; e.wdbus = 16'hDEAD; e.busy = 1; e.rdata = model_rdata;
                        q.push_back(e);
                        sq.push_back({1'b0, 16'hDEAD});
                    end
                end
                d = wq.pop_front();
                e = blank();
                e.wready = 1; e.wr = 1; e.addr = ad; e.wdbus = d; e.busy = 1; e.rdata = model_rdata;
                q.push_back(e);
                sq.push_back({1'b1, d});
                model_mem[ad] = d;
            end
        end
        e = blank();
        e.done = 1; e.busy = 1; e.err = trunc;
        if (!wr) begin
            model_rdata = model_mem[a + 16'(beats - 1)];
            e.rvalid = 1;
        end
        e.rdata = model_rdata;
        q.push_back(e);
        model_err = trunc;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 2000) begin
            @(posedge CLK);
            n++;
        end
        #1;
        if (q.size() > 0) begin
            chk("drain_timeout", q.size(), 0);
            q.delete();
        end
    endtask

    task automatic set_req(input bit wr, input logic [15:0] a, input logic [7:0] len);
        bus.REQ_WRITE = wr;
        bus.REQ_ADDR  = a;
        bus.REQ_LEN   = len;
        bus.REQ_VALID = 1'b1;
    endtask

    task automatic run_cmd(input bit wr, input logic [15:0] a, input logic [7:0] len, input int gap);
        build(wr, a, len, gap);
        set_req(wr, a, len);
        @(posedge CLK); #1;
        bus.REQ_VALID = 1'b0;
        while (sq.size() > 0) begin
            {bus.WDATA_VALID, bus.WDATA} = sq.pop_front();
            @(posedge CLK); #1;
        end
        bus.WDATA_VALID = 1'b0;
        bus.WDATA       = 16'hDEAD;
        drain();
    endtask

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        model_mem[a] = d;
        @(posedge CLK); #1;
        pre_we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic exp_err_wrap;
        logic [15:0] exp_rdata_wrap;
        int exp_rd0;
        RST = 1'b0;
        bus.REQ_VALID = 0; bus.REQ_WRITE = 0; bus.REQ_ADDR = 0; bus.REQ_LEN = 0;
        bus.WDATA = 16'hDEAD; bus.WDATA_VALID = 0;
        #3;
        chk("rst_req_ready", bus.REQ_READY, 1);
        chk("rst_busy", bus.BUSY, 0);
        chk("rst_rd", bus.RD, 0);
        chk("rst_addr", bus.ADDR, 0);
        @(posedge CLK); #1;
        RST = 1'b1;
        chk_en = 1;

        preload(16'h05AA, 16'h0BF0);
        preload(16'hFFFF, 16'hA001);
        preload(16'h0000, 16'hA002);
        preload(16'h0001, 16'hA003);
        preload(16'h0300, 16'h7777);
        preload(16'h0400, 16'h5A5A);

        // single read
        run_cmd(0, 16'h05AA, 8'd0, 0);
        chk("single_rdata", bus.RDATA, 16'h0BF0);
        chk("single_done_cnt", done_cnt, 1);

        // 4-beat write then read-back
        wq.push_back(16'h1111); wq.push_back(16'h2222); wq.push_back(16'h3333); wq.push_back(16'h4444);
        run_cmd(1, 16'h2910, 8'd3, 0);
        chk("wr_mem_2910", mem[16'h2910], 16'h1111);
        chk("wr_mem_2913", mem[16'h2913], 16'h4444);
        run_cmd(0, 16'h2910, 8'd3, 0);
        chk("rb_last_rdata", bus.RDATA, 16'h4444);

        // write with 3-cycle stall between beats
        wq.push_back(16'hC0DE); wq.push_back(16'hBEEF);
        run_cmd(1, 16'h0010, 8'd1, 3);
        chk("stall_mem_0010", mem[16'h0010], 16'hC0DE);
        chk("stall_mem_0011", mem[16'h0011], 16'hBEEF);
        chk("stall_done_cnt", done_cnt, 4);

        // read across the top of the address space
`ifdef MEM_WRAP_CHK_EN
        exp_err_wrap = 1'b1; exp_rdata_wrap = 16'hA001; exp_rd0 = 0;
`else
        exp_err_wrap = 1'b0; exp_rdata_wrap = 16'hA003; exp_rd0 = 1;
`endif
        run_cmd(0, 16'hFFFF, 8'd2, 0);
        chk("wrap_err", bus.ERR, exp_err_wrap);
        chk("wrap_rdata", bus.RDATA, exp_rdata_wrap);
        chk("wrap_rd_at_0", rd0_cnt, exp_rd0);

        // back-to-back commands with REQ_VALID held high
        build(0, 16'h2910, 8'd1, 0);
        build(0, 16'h05AA, 8'd0, 0);
        set_req(0, 16'h2910, 8'd1);
        @(posedge CLK); #1;
        bus.REQ_ADDR = 16'h05AA;
        bus.REQ_LEN  = 8'd0;
        repeat (4) @(posedge CLK);
        #1;
        bus.REQ_VALID = 1'b0;
        drain();
        chk("b2b_done_cnt", done_cnt, 7);
        chk("b2b_rdata", bus.RDATA, 16'h0BF0);

        // asynchronous reset during the second beat of an 8-beat read
        build(0, 16'h0300, 8'd7, 0);
        set_req(0, 16'h0300, 8'd7);
        @(posedge CLK); #1;
        bus.REQ_VALID = 1'b0;
        @(posedge CLK); #6;
        chk_en = 0;
        q.delete();
        RST = 1'b0;
        #1;
        chk("arst_rd", bus.RD, 0);
        chk("arst_busy", bus.BUSY, 0);
        chk("arst_req_ready", bus.REQ_READY, 1);
        chk("arst_addr", bus.ADDR, 0);
        chk("arst_rvalid", bus.RDATA_VALID, 0);
        chk("arst_rdata", bus.RDATA, 0);
        chk("arst_done", bus.DONE, 0);
        repeat (2) @(posedge CLK);
        #3;
        RST = 1'b1;
        model_rdata = 16'h0000;
        model_err = 1'b0;
        @(posedge CLK); #1;
        chk_en = 1;
        repeat (3) @(posedge CLK);
        #1;
        chk("arst_no_done", done_cnt, 7);

        run_cmd(0, 16'h0400, 8'd0, 0);
        chk("post_rst_rdata", bus.RDATA, 16'h5A5A);
        chk("post_rst_done_cnt", done_cnt, 8);

        repeat (2) @(posedge CLK);
        #1;
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_burst_master.md
Name: mem_burst_master

Overview:
- Bus initiator for the 16-bit single-port memory interface: ADDR, RD, WR, WDBUS, RDBUS.
- Accepts burst read/write commands from a client over a valid/ready handshake.
- Issues one memory beat per cycle at incrementing addresses.
- Returns read data as a stream, and takes write data from a stream.
- Sits between the datapath/loader logic and the memory block.

Parameters:
- AW, 16, address width (ADDR, REQ_ADDR)
- DW, 16, data width (WDBUS, RDBUS, WDATA, RDATA)
- LW, 8, burst length field width; beats = REQ_LEN+1

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  asynchronous active-low reset
- REQ_VALID  in  1  command valid
- REQ_READY  out  1  command accepted when REQ_VALID&&REQ_READY at rising edge
- REQ_WRITE  in  1  1=write burst, 0=read burst
- REQ_ADDR  in  AW  burst start address
- REQ_LEN  in  LW  beats minus one
- WDATA  in  DW  write stream data
- WDATA_VALID  in  1  write data valid
- WDATA_READY  out  1  write data accepted when both high at rising edge
- RDATA  out  DW  read data (registered)
- RDATA_VALID  out  1  one-cycle qualifier per read beat; no backpressure
- BUSY  out  1  burst in progress (state != IDLE)
- DONE  out  1  one-cycle pulse at burst completion
- ERR  out  1  see Optional Feature; tied 0 when feature absent
- ADDR  out  AW  memory address
- WDBUS  out  DW  memory write data
- RDBUS  in  DW  memory read data; combinational from ADDR while RD=1
- RD  out  1  memory read strobe
- WR  out  1  memory write strobe; memory writes at rising edge while WR=1

Behaviour:
- Reset (RST=0, asynchronous, any state):
  - state=IDLE; address and beat counters cleared.
  - All outputs 0 except REQ_READY=1.
  - An in-flight burst is abandoned and emits no DONE.
- States:
  - IDLE: REQ_READY=1. On handshake, latch REQ_ADDR into cur_addr, REQ_LEN into remaining, and REQ_WRITE. Go to READ or WRITE.
  - READ: RD=1, ADDR=cur_addr. At each rising edge:
    - RDATA<=RDBUS and RDATA_VALID<=1.
    - cur_addr+1; remaining-1.
    - On the beat where remaining==0, go to FINISH.
  - WRITE: WDATA_READY=1, ADDR=cur_addr, WDBUS=WDATA, WR=WDATA_VALID (combinational).
    - On handshake: cur_addr+1, remaining-1. After the beat where remaining==0, go to FINISH.
    - WDATA_VALID=0: stall. ADDR holds, WR=0, no timeout.
  - FINISH: DONE=1 for exactly this cycle, then IDLE. REQ_READY=0 in FINISH.
- Output rules outside active states:
  - RD, WR, WDATA_READY are 0 outside READ/WRITE.
  - ADDR and WDBUS are 0 in IDLE and FINISH.
- Read latency:
  - Command accepted at edge N.
  - RD high in cycles N+1 .. N+L+1.
  - Data for beat k valid on RDATA in cycle N+2+k.
  - Final RDATA_VALID coincides with DONE.
- Arithmetic:
  - cur_addr increments modulo 2^AW; 0xFFFF wraps to 0x0000.
  - REQ_LEN=0 means 1 beat; REQ_LEN=255 means 256 beats.
- RDATA holds its last value when RDATA_VALID=0.
- REQ_* are ignored while BUSY. A new command is accepted at the earliest in the cycle after FINISH (IDLE).

Optional Feature:
- Macro: MEM_WRAP_CHK_EN.
- Defined:
  - A beat whose cur_addr is 0xFFFF and has remaining>0 completes normally.
  - The burst then terminates: go to FINISH, DONE pulses, ERR=1 with DONE.
  - ERR is sticky until the next accepted command or reset.
  - Beats that would have wrapped to 0x0000 are not issued (no RD/WR at 0x0000).
- Undefined: addresses wrap silently; ERR is constant 0.

Test Plan:
- Single read: preload MEM[0x05AA]=0x0BF0; REQ addr 0x05AA, len 0, read -> RD high 1 cycle with ADDR=0x05AA; next cycle RDATA=0x0BF0, RDATA_VALID=1, DONE=1.
- Burst write then read-back: write 4 beats at 0x2910, data 0x1111,0x2222,0x3333,0x4444, WDATA_VALID continuous -> WR high 4 cycles at ADDR 0x2910..0x2913. Read-back len 3 returns the same 4 words on consecutive cycles.
- Write stall: 2-beat write at 0x0010, WDATA_VALID low 3 cycles between beats -> WR=0 and ADDR=0x0011 held during gap; MEM[0x0010..0x0011] correct; DONE once.
- Wrap: read len 2 at 0xFFFF:
  - Feature off -> beats at 0xFFFF,0x0000,0x0001; ERR=0.
  - Feature on -> one beat at 0xFFFF only; DONE and ERR=1.
- Reset mid-burst: assert RST=0 asynchronously during beat 2 of an 8-beat read -> outputs clear immediately without waiting for CLK; REQ_READY=1; no DONE. A subsequent 1-beat read succeeds.
- Back-to-back commands: REQ_VALID held high with two read commands -> second accepted only after FINISH; BUSY low exactly one cycle between bursts.
